// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style receiver: FSM states, instruction codes,
// DDRAM layout (two 16-character lines at 0x00 and 0x40) and the blank character.
package lcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_BUSY
   } lcd_state_e;

   localparam logic [7:0] INS_CLEAR     = 8'h01;
   localparam logic [7:0] INS_HOME      = 8'h02;
   localparam logic [7:0] INS_ENTRY     = 8'h04;
   localparam logic [7:0] INS_DISPLAY   = 8'h08;
   localparam logic [7:0] INS_NOEFFECT  = 8'h70;
   localparam logic [7:0] INS_SET_DDRAM = 8'h80;

   localparam logic [6:0] LINE1_BASE = 7'h00;
   localparam logic [6:0] LINE2_BASE = 7'h40;
   localparam int         LINE_LEN   = 16;
   localparam logic [7:0] SPACE_CHAR = 8'h20;

endpackage

// File: rtl/lcd_addr_step.sv
// DDRAM address counter step (wrapping between the two lines) and address-to-buffer mapping.
// Purely combinational; no latency, no flow control.
module lcd_addr_step
   import lcd_pkg::*;
(
   input  logic [6:0] addr,
   input  logic       inc,
   output logic [6:0] next_addr,
   output logic [4:0] buf_idx
);

   localparam logic [6:0] LAST = 7'(LINE_LEN - 1);

   always_comb begin
      buf_idx = {addr[6], addr[3:0]};
      if (inc) begin
         if (addr == LINE1_BASE + LAST)      next_addr = LINE2_BASE;
         else if (addr == LINE2_BASE + LAST) next_addr = LINE1_BASE;
         else                                next_addr = addr + 7'd1;
      end else begin
         if (addr == LINE1_BASE)             next_addr = LINE2_BASE + LAST;
         else if (addr == LINE2_BASE)        next_addr = LINE1_BASE + LAST;
         else                                next_addr = addr - 7'd1;
      end
   end

endmodule

// File: rtl/lcd_hd44780_rx.sv
// HD44780-compatible bus receiver: decodes lcd_e strobes into a 32-char buffer, one cycle after the falling edge.
// No backpressure: writes arriving while busy are dropped with a cmd_err pulse; busy-flag reads always served.
module lcd_hd44780_rx
   import lcd_pkg::*;
#(
   parameter int CMD_CYCLES = 2000,
   parameter int CLR_CYCLES = 82000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] data_lcd,
   output logic [7:0] db_o,
   output logic       db_oe,
   input  logic       lcd_on,
   input  logic       lcd_blon,
   input  logic [4:0] rd_idx,
   output logic [7:0] rd_char,
   output logic       busy,
   output logic       display_on,
   output logic [6:0] cur_addr,
   output logic       cmd_err
);

   localparam int CNT_W = $clog2((CLR_CYCLES > CMD_CYCLES ? CLR_CYCLES : CMD_CYCLES) + 1);

   lcd_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             e_q, rs_q, rw_q;
   logic [7:0]       dat_q;
   logic [6:0]       cur_addr_q, cur_addr_d;
   logic             inc_q, inc_d;
   logic             disp_q, disp_d;
   logic             err_q, err_d;
   logic [7:0]       buf_mem_q [32];

   logic             fall, we;
   logic [4:0]       widx, step_idx;
   logic [7:0]       wdat;
   logic [6:0]       step_next;
   logic             unused_blon;

   assign unused_blon = lcd_blon;

   lcd_addr_step u_step (
      .addr      (cur_addr_q),
      .inc       (inc_q),
      .next_addr (step_next),
      .buf_idx   (step_idx)
   );

   assign fall = lcd_on & e_q & ~lcd_e;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cur_addr_d = cur_addr_q;
      inc_d      = inc_q;
      disp_d     = disp_q;
      err_d      = 1'b0;
      we         = 1'b0;
      widx       = step_idx;
      wdat       = dat_q;

      case (state_q)
         ST_CLEAR: begin
            we   = 1'b1;
            widx = cnt_q[4:0];
            wdat = SPACE_CHAR;
            if (cnt_q[4:0] == 5'd31) begin
               cur_addr_d = LINE1_BASE;
               inc_d      = 1'b1;
               cnt_d      = CNT_W'(CLR_CYCLES - 32);
               state_d    = (CLR_CYCLES == 32) ? ST_IDLE : ST_BUSY;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_BUSY: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: ;
      endcase

      // A busy-flag read has no side effects, so it never competes with the timer.
      if (fall && !(!rs_q && rw_q)) begin
         if (state_q != ST_IDLE) begin
            err_d = 1'b1;
         end else if (rw_q) begin
            cur_addr_d = step_next;
         end else if (rs_q) begin
            we         = 1'b1;
            cur_addr_d = step_next;
            state_d    = ST_BUSY;
            cnt_d      = CNT_W'(CMD_CYCLES);
         end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_W'(CMD_CYCLES);
            if (|(dat_q & INS_SET_DDRAM)) begin
               if (dat_q[5:4] == 2'b00) begin
                  cur_addr_d = dat_q[6:0];
               end else begin
                  err_d   = 1'b1;
                  state_d = state_q;
                  cnt_d   = cnt_q;
               end
            end else if (|(dat_q & INS_NOEFFECT)) begin
               state_d = ST_BUSY;
            end else if (|(dat_q & INS_DISPLAY)) begin
               disp_d = dat_q[2];
            end else if (|(dat_q & INS_ENTRY)) begin
               inc_d = dat_q[1];
            end else if (|(dat_q & INS_HOME)) begin
               cur_addr_d = LINE1_BASE;
            end else if (|(dat_q & INS_CLEAR)) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end else begin
               err_d   = 1'b1;
               state_d = state_q;
               cnt_d   = cnt_q;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         e_q        <= 1'b0;
         rs_q       <= 1'b0;
         rw_q       <= 1'b0;
         dat_q      <= '0;
         cur_addr_q <= LINE1_BASE;
         inc_q      <= 1'b1;
         disp_q     <= 1'b0;
         err_q      <= 1'b0;
         for (int i = 0; i < 32; i++) buf_mem_q[i] <= SPACE_CHAR;
      end else begin
         e_q   <= lcd_on & lcd_e;
         err_q <= err_d;
         if (lcd_on && lcd_e) begin
            rs_q  <= lcd_rs;
            rw_q  <= lcd_rw;
            dat_q <= data_lcd;
         end
         if (lcd_on) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_addr_q <= cur_addr_d;
            inc_q      <= inc_d;
            disp_q     <= disp_d;
            if (we) buf_mem_q[widx] <= wdat;
         end
      end
   end

   always_comb begin
      db_oe = 1'b0;
      db_o  = '0;
      if (lcd_on && lcd_e && lcd_rw) begin
         if (!lcd_rs) begin
            db_oe = 1'b1;
            db_o  = {busy, cur_addr_q};
         end else if (state_q == ST_IDLE) begin
            db_oe = 1'b1;
            db_o  = buf_mem_q[step_idx];
         end
      end
   end

   assign rd_char    = buf_mem_q[rd_idx];
   assign busy       = (state_q != ST_IDLE);
   assign display_on = disp_q;
   assign cur_addr   = cur_addr_q;
   assign cmd_err    = err_q;

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// Directed bench for lcd_hd44780_rx with short busy timers; every expectation is hand-derived.
module tb_lcd_hd44780_rx;

   localparam int CMD = 20;
   localparam int CLR = 100;

   logic       clk_i = 1'b0, rst_i = 1'b1;
   logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
   logic       lcd_on = 1'b1, lcd_blon = 1'b0;
   logic [7:0] data_lcd = '0;
   logic [4:0] rd_idx = '0;
   logic [7:0] db_o, rd_char;
   logic       db_oe, busy, display_on, cmd_err;
   logic [6:0] cur_addr;

   int tests = 0;
   int failed = 0;

   lcd_hd44780_rx #(.CMD_CYCLES(CMD), .CLR_CYCLES(CLR)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
      .data_lcd(data_lcd), .db_o(db_o), .db_oe(db_oe), .lcd_on(lcd_on), .lcd_blon(lcd_blon),
      .rd_idx(rd_idx), .rd_char(rd_char), .busy(busy), .display_on(display_on),
      .cur_addr(cur_addr), .cmd_err(cmd_err)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic bus_cycle(input logic rs, input logic rw, input logic [7:0] d,
                            output logic [7:0] dbv, output logic dbe);
      @(posedge clk_i); #1;
      lcd_rs = rs; lcd_rw = rw; data_lcd = d; lcd_e = 1'b1;
      #4;
      dbv = db_o; dbe = db_oe;
      @(posedge clk_i); #1;
      lcd_e = 1'b0;
      @(posedge clk_i); #1;
   endtask

   task automatic wr(input logic rs, input logic [7:0] d);
      logic [7:0] v;
      logic       e;
      bus_cycle(rs, 1'b0, d, v, e);
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 4 * CLR) begin
         @(posedge clk_i); #1;
         n++;
      end
   endtask

   task automatic wr_wait(input logic rs, input logic [7:0] d, output int n);
      wr(rs, d);
      wait_idle(n);
   endtask

   task automatic read_buf(input int i, output logic [7:0] v);
      rd_idx = 5'(i);
      #1;
      v = rd_char;
   endtask

   task automatic count_bad(input logic [7:0] base, input logic ramp, output int bad);
      logic [7:0] v;
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         read_buf(i, v);
         if (v !== (ramp ? 8'(base + 8'(i)) : base)) bad++;
      end
   endtask

   task automatic test_reset();
      int bad;
      #12;
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", busy); end
      tests++; if (display_on !== 1'b0) begin failed++; $display("FAIL reset_disp got %b want 0", display_on); end
      tests++; if (cur_addr !== 7'h00) begin failed++; $display("FAIL reset_addr got %h want 00", cur_addr); end
      tests++; if ({cmd_err, db_oe, db_o} !== 10'h0) begin failed++; $display("FAIL reset_outs got %b%b%h want 0", cmd_err, db_oe, db_o); end
      count_bad(8'h20, 1'b0, bad);
      tests++; if (bad !== 0) begin failed++; $display("FAIL reset_buf got %0d non-space want 0", bad); end
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic test_basic();
      logic [7:0] seq [6];
      logic       rs  [6];
      logic [7:0] v;
      int         n;
      seq = '{8'h38, 8'h0C, 8'h06, 8'h80, 8'h48, 8'h49};
      rs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         wr_wait(rs[i], seq[i], n);
         tests++; if (n !== CMD) begin failed++; $display("FAIL basic_busy_len[%0d] got %0d want %0d", i, n, CMD); end
      end
      tests++; if (display_on !== 1'b1) begin failed++; $display("FAIL basic_disp got %b want 1", display_on); end
      read_buf(0, v);
      tests++; if (v !== 8'h48) begin failed++; $display("FAIL basic_buf0 got %h want 48", v); end
      read_buf(1, v);
      tests++; if (v !== 8'h49) begin failed++; $display("FAIL basic_buf1 got %h want 49", v); end
      tests++; if (cur_addr !== 7'h02) begin failed++; $display("FAIL basic_addr got %h want 02", cur_addr); end
   endtask

   task automatic test_line_wrap();
      logic [7:0] v;
      int         n;
      wr_wait(1'b0, 8'h8F, n);
      wr_wait(1'b1, 8'h41, n);
      wr_wait(1'b1, 8'h42, n);
      read_buf(15, v);
      tests++; if (v !== 8'h41) begin failed++; $display("FAIL wrap_buf15 got %h want 41", v); end
      read_buf(16, v);
      tests++; if (v !== 8'h42) begin failed++; $display("FAIL wrap_buf16 got %h want 42", v); end
      tests++; if (cur_addr !== 7'h41) begin failed++; $display("FAIL wrap_addr_inc got %h want 41", cur_addr); end
      wr_wait(1'b0, 8'h04, n);
      wr_wait(1'b0, 8'hC0, n);
      wr_wait(1'b1, 8'h5A, n);
      read_buf(16, v);
      tests++; if (v !== 8'h5A) begin failed++; $display("FAIL wrap_buf16_dec got %h want 5a", v); end
      tests++; if (cur_addr !== 7'h0F) begin failed++; $display("FAIL wrap_addr_dec got %h want 0f", cur_addr); end
      wr_wait(1'b0, 8'h06, n);
   endtask

   task automatic test_data_read();
      logic [7:0] v;
      logic       e;
      int         n;
      wr_wait(1'b0, 8'h80, n);
      bus_cycle(1'b1, 1'b1, 8'h00, v, e);
      tests++; if ({e, v} !== {1'b1, 8'h48}) begin failed++; $display("FAIL dread_db got %b/%h want 1/48", e, v); end
      tests++; if ({busy, cur_addr} !== {1'b0, 7'h01}) begin failed++; $display("FAIL dread_step got %b/%h want 0/01", busy, cur_addr); end
      bus_cycle(1'b0, 1'b1, 8'h00, v, e);
      tests++; if ({e, v} !== {1'b1, 8'h01}) begin failed++; $display("FAIL bfread_idle got %b/%h want 1/01", e, v); end
   endtask

   task automatic test_busy_drop();
      logic [7:0] v;
      logic       e;
      int         n;
      wr(1'b0, 8'h85);
      wr(1'b1, 8'h51);
      tests++; if (cmd_err !== 1'b1) begin failed++; $display("FAIL drop_err got %b want 1", cmd_err); end
      @(posedge clk_i); #1;
      tests++; if (cmd_err !== 1'b0) begin failed++; $display("FAIL drop_err_pulse got %b want 0", cmd_err); end
      bus_cycle(1'b0, 1'b1, 8'h00, v, e);
      tests++; if ({e, v} !== {1'b1, 8'h85}) begin failed++; $display("FAIL bfread_busy got %b/%h want 1/85", e, v); end
      wait_idle(n);
      read_buf(5, v);
      tests++; if (v !== 8'h20) begin failed++; $display("FAIL drop_buf5 got %h want 20", v); end
      tests++; if (cur_addr !== 7'h05) begin failed++; $display("FAIL drop_addr got %h want 05", cur_addr); end
   endtask

   task automatic test_expiry_collision();
      logic [7:0] v;
      wr(1'b0, 8'h86);
      repeat (CMD - 3) @(posedge clk_i);
      wr(1'b1, 8'h55);
      tests++; if ({cmd_err, busy} !== 2'b10) begin failed++; $display("FAIL expiry_err_busy got %b%b want 10", cmd_err, busy); end
      read_buf(6, v);
      tests++; if ({v, 1'b0, cur_addr} !== {8'h20, 8'h06}) begin failed++; $display("FAIL expiry_state got %h/%h want 20/06", v, cur_addr); end
   endtask

   task automatic test_invalid_addr();
      int n;
      wr(1'b0, 8'h95);
      tests++; if ({cmd_err, 1'b0, cur_addr} !== {1'b1, 8'h06}) begin failed++; $display("FAIL badaddr got %b/%h want 1/06", cmd_err, cur_addr); end
      wait_idle(n);
   endtask

   task automatic test_lcd_off();
      lcd_on = 1'b0;
      wr(1'b0, 8'h8A);
      tests++; if ({busy, cmd_err, cur_addr} !== {2'b00, 7'h06}) begin failed++; $display("FAIL off_hold got %b%b/%h want 00/06", busy, cmd_err, cur_addr); end
      lcd_on = 1'b1;
      @(posedge clk_i); #1;
   endtask

   task automatic test_clear();
      logic [7:0] v31, v32, v;
      logic [6:0] a31, a32;
      int         n, bad;
      wr_wait(1'b0, 8'h80, n);
      for (int i = 0; i < 32; i++) wr_wait(1'b1, 8'(8'h61 + 8'(i)), n);
      count_bad(8'h61, 1'b1, bad);
      tests++; if (bad !== 0) begin failed++; $display("FAIL fill_buf got %0d wrong want 0", bad); end
      wr_wait(1'b0, 8'h83, n);
      wr_wait(1'b0, 8'h04, n);
      rd_idx = 5'd31;
      wr(1'b0, 8'h01);
      n = 0; v31 = '0; v32 = '0; a31 = '0; a32 = '0;
      while (busy && n < 4 * CLR) begin
         @(posedge clk_i); #1;
         n++;
         if (n == 31) begin v31 = rd_char; a31 = cur_addr; end
         if (n == 32) begin v32 = rd_char; a32 = cur_addr; end
      end
      tests++; if (n !== CLR) begin failed++; $display("FAIL clear_busy_len got %0d want %0d", n, CLR); end
      tests++; if ({v31, 1'b0, a31} !== {8'h80, 8'h03}) begin failed++; $display("FAIL clear_cyc31 got %h/%h want 80/03", v31, a31); end
      tests++; if ({v32, 1'b0, a32} !== {8'h20, 8'h00}) begin failed++; $display("FAIL clear_cyc32 got %h/%h want 20/00", v32, a32); end
      count_bad(8'h20, 1'b0, bad);
      tests++; if (bad !== 0) begin failed++; $display("FAIL clear_buf got %0d non-space want 0", bad); end
      wr_wait(1'b1, 8'h58, n);
      read_buf(0, v);
      tests++; if ({v, 1'b0, cur_addr} !== {8'h58, 8'h01}) begin failed++; $display("FAIL clear_incmode got %h/%h want 58/01", v, cur_addr); end
   endtask

   task automatic test_reset_mid_clear();
      int n, bad;
      wr_wait(1'b0, 8'hCF, n);
      wr_wait(1'b1, 8'h59, n);
      wr_wait(1'b0, 8'hC5, n);
      wr(1'b0, 8'h01);
      repeat (10) @(posedge clk_i);
      #3 rst_i = 1'b1;
      #1;
      tests++; if ({busy, display_on, cur_addr} !== 9'h000) begin failed++; $display("FAIL rstmid_state got %b%b/%h want 00/00", busy, display_on, cur_addr); end
      count_bad(8'h20, 1'b0, bad);
      tests++; if (bad !== 0) begin failed++; $display("FAIL rstmid_buf got %0d non-space want 0", bad); end
      @(negedge clk_i);
      rst_i = 1'b0;
      wr_wait(1'b0, 8'h0C, n);
      tests++; if (n !== CMD || display_on !== 1'b1) begin failed++; $display("FAIL rstmid_after got %0d/%b want %0d/1", n, display_on, CMD); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_line_wrap();
      test_data_read();
      test_busy_drop();
      test_expiry_collision();
      test_invalid_addr();
      test_lcd_off();
      test_clear();
      test_reset_mid_clear();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
